// File: rtl/uart_rx_ctrl_if.sv
// uart_rx_ctrl_if
//   Bundles the signals between the UART receive frame controller and the
//   rest of the receive datapath (edge/bit counter, data sampler,
//   deserializer, status consumers).
//
// Signal summary:
//   RX_IN        serial line, idle high
//   PAR_EN       1 = frame carries a parity bit
//   PAR_TYP      0 = even parity, 1 = odd parity
//   Prescale     oversampling ratio (8, 16 or 32)
//   edge_cnt     oversampling edge position within the current bit
//   bit_cnt      bit position within the frame (0 = start)
//   sampled_bit  majority-sampled line value, valid at the check point
//   cnt_enable   enable to the edge/bit counter
//   smp_enable   enable to the data sampler
//   deser_en     one-cycle shift strobe per data bit
//   data_valid   one-cycle frame-good pulse
//   par_err      parity error, held until the next frame start
//   stp_err      stop (framing) error, held until the next frame start
//   strt_glitch  one-cycle false-start pulse
//   err_cnt      errored-frame count
//
// Modports:
//   master  the frame controller side
//   slave   the datapath side that feeds the controller and uses its outputs
interface uart_rx_ctrl_if;
  logic       RX_IN;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [5:0] Prescale;
  logic [4:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       sampled_bit;
  logic       cnt_enable;
  logic       smp_enable;
  logic       deser_en;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;
  logic       strt_glitch;
  logic [7:0] err_cnt;

  modport master (
    input  RX_IN, PAR_EN, PAR_TYP, Prescale, edge_cnt, bit_cnt, sampled_bit,
    output cnt_enable, smp_enable, deser_en, data_valid, par_err, stp_err,
           strt_glitch, err_cnt
  );

  modport slave (
    output RX_IN, PAR_EN, PAR_TYP, Prescale, edge_cnt, bit_cnt, sampled_bit,
    input  cnt_enable, smp_enable, deser_en, data_valid, par_err, stp_err,
           strt_glitch, err_cnt
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl
//   Frame-sequencing FSM for the UART receive path, running on the RX
//   oversampling clock. It enables the edge counter and data sampler for the
//   duration of a frame, consumes the sampled bit at each bit's check point,
//   strobes the deserializer for every data bit, checks for false starts,
//   parity and stop errors, and pulses data_valid for an error-free frame.
//
// Ports:
//   clk    oversampling clock
//   SRST   synchronous reset, active-high
//   bus    uart_rx_ctrl_if.master (see the interface file for signal list)
//
// Parameters:
//   CHK_OFS  check point offset; the check cycle is the one where
//            edge_cnt == (Prescale >> 1) + CHK_OFS (5-bit arithmetic)
//
// Build option:
//   UART_RX_ERR_CNT_EN  when defined, err_cnt is an 8-bit saturating count
//                       of errored frames (parity, stop or false start);
//                       otherwise err_cnt is tied to zero.
module uart_rx_ctrl #(
  parameter int CHK_OFS = 2
) (
  input  logic           clk,
  input  logic           SRST,
  uart_rx_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [4:0] w_chk;
  logic       w_check;
  logic       r_acc;
  logic       r_data_valid;
  logic       r_par_err;
  logic       r_stp_err;
  logic       r_strt_glitch;
  logic       w_start_entry;
  logic       w_glitch;
  logic       w_par_set;
  logic       w_stp_set;
  logic       w_frame_good;

  // The check point sits a couple of oversampling edges past mid-bit so the
  // majority sampler has already settled on its value.
  assign w_chk   = 5'((bus.Prescale >> 1) + 6'(CHK_OFS));
  assign w_check = (bus.edge_cnt == w_chk);

  // Frame events, shared by the next-state logic, the status registers and
  // the optional error counter.
  assign w_start_entry = (r_state == IDLE) && !bus.RX_IN;
  assign w_glitch      = (r_state == START) && w_check &&
                         (bus.bit_cnt == 4'd0) && bus.sampled_bit;
  assign w_par_set     = (r_state == PARITY) && w_check &&
                         (bus.sampled_bit != (r_acc ^ bus.PAR_TYP));
  assign w_stp_set     = (r_state == STOP) && w_check && !bus.sampled_bit;
  assign w_frame_good  = (r_state == STOP) && w_check && bus.sampled_bit &&
                         !r_par_err;

  // State register.
  always_ff @(posedge clk) begin
    if (SRST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic. START and DATA advance as soon as the counter rolls
  // into the following bit, so the check cycle of bit 9/10 is never seen
  // by DATA. STOP returns to IDLE right after its check so the remaining
  // half stop bit is slack for a back-to-back start.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (!bus.RX_IN) begin
          w_next = START;
        end
      end
      START: begin
        if (w_glitch) begin
          w_next = IDLE;
        end else if (bus.bit_cnt == 4'd1) begin
          w_next = DATA;
        end
      end
      DATA: begin
        if (bus.bit_cnt == 4'd9) begin
          w_next = bus.PAR_EN ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (bus.bit_cnt == 4'd10) begin
          w_next = STOP;
        end
      end
      STOP: begin
        if (w_check) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Output decode from the state register; the shift strobe is the only
  // combinational pulse and lands in the data bit's check cycle.
  always_comb begin
    bus.cnt_enable = (r_state != IDLE);
    bus.smp_enable = (r_state != IDLE);
    bus.deser_en   = (r_state == DATA) && w_check;
  end

  // Registered status: pulses for one cycle after the triggering check,
  // sticky errors until the next frame start, and the running parity of
  // the data bits.
  always_ff @(posedge clk) begin
    if (SRST) begin
      r_data_valid  <= 1'b0;
      r_strt_glitch <= 1'b0;
      r_par_err     <= 1'b0;
      r_stp_err     <= 1'b0;
      r_acc         <= 1'b0;
    end else begin
      r_data_valid  <= w_frame_good;
      r_strt_glitch <= w_glitch;
      if (w_start_entry) begin
        r_par_err <= 1'b0;
        r_stp_err <= 1'b0;
        r_acc     <= 1'b0;
      end else begin
        if (w_par_set) begin
          r_par_err <= 1'b1;
        end
        if (w_stp_set) begin
          r_stp_err <= 1'b1;
        end
        if ((r_state == DATA) && w_check) begin
          r_acc <= r_acc ^ bus.sampled_bit;
        end
      end
    end
  end

  assign bus.data_valid  = r_data_valid;
  assign bus.strt_glitch = r_strt_glitch;
  assign bus.par_err     = r_par_err;
  assign bus.stp_err     = r_stp_err;

`ifdef UART_RX_ERR_CNT_EN
  logic [7:0] r_err_cnt;
  logic       w_err_inc;

  // A frame is counted once: a stop error that follows a parity error in the
  // same frame is already covered because par_err is still held.
  assign w_err_inc = w_par_set | (w_stp_set & ~r_par_err) | w_glitch;

  // Saturating errored-frame counter, cleared only by reset.
  always_ff @(posedge clk) begin
    if (SRST) begin
      r_err_cnt <= 8'd0;
    end else if (w_err_inc && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign bus.err_cnt = r_err_cnt;
`else
  assign bus.err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl
//   Directed self-checking bench for uart_rx_ctrl. The bench models the
//   external edge/bit counter and drives sampled_bit straight from a frame
//   bit vector indexed by bit_cnt. A negedge monitor counts pulses,
//   rebuilds the deserialized byte and checks strobe timing.
module tb_uart_rx_ctrl;

  logic clk;
  logic SRST;

  uart_rx_ctrl_if bus ();

  uart_rx_ctrl #(.CHK_OFS(2)) dut (
    .clk  (clk),
    .SRST (SRST),
    .bus  (bus)
  );

  logic [15:0] frameBits;
  int          testsRun;
  int          testsFailed;
  int          chkExp;
  int          deserCount;
  int          dvCount;
  int          glitchCount;
  int          cntEnCycles;
  int          badTiming;
  int          expErrModel;
  logic        prevStopCheck;
  logic [7:0]  shreg;
  logic [7:0]  dvBytes[$];

  // Free-running oversampling clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the bench can never hang.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // External edge/bit counter: cleared whenever the controller disables it.
  always @(posedge clk) begin
    if (SRST || !bus.cnt_enable) begin
      bus.edge_cnt <= 5'd0;
      bus.bit_cnt  <= 4'd0;
    end else if (6'(bus.edge_cnt) == bus.Prescale - 6'd1) begin
      bus.edge_cnt <= 5'd0;
      bus.bit_cnt  <= bus.bit_cnt + 4'd1;
    end else begin
      bus.edge_cnt <= bus.edge_cnt + 5'd1;
    end
  end

  assign bus.sampled_bit = frameBits[bus.bit_cnt];

  // Monitor: pulse counts, rebuilt byte and strobe timing checks.
  always @(negedge clk) begin
    if (bus.deser_en) begin
      deserCount++;
      shreg = {bus.sampled_bit, shreg[7:1]};
      if (int'(bus.edge_cnt) != chkExp) badTiming++;
    end
    if (bus.data_valid) begin
      dvCount++;
      dvBytes.push_back(shreg);
      if (!prevStopCheck) badTiming++;
    end
    if (bus.strt_glitch) glitchCount++;
    if (bus.cnt_enable) cntEnCycles++;
    prevStopCheck = bus.cnt_enable && (int'(bus.edge_cnt) == chkExp) &&
                    (bus.bit_cnt == (bus.PAR_EN ? 4'd10 : 4'd9));
  end

  function automatic logic [15:0] makeFrame(input logic [7:0] d, input logic pe,
                                            input logic pb, input logic sb);
    logic [15:0] f;
    f      = 16'hFFFF;
    f[0]   = 1'b0;
    f[8:1] = d;
    if (pe) begin
      f[9]  = pb;
      f[10] = sb;
    end else begin
      f[9] = sb;
    end
    return f;
  endfunction

  function automatic int expErr();
`ifdef UART_RX_ERR_CNT_EN
    return expErrModel;
`else
    return 0;
`endif
  endfunction

  function automatic int firstByte(input int idx);
    if (dvBytes.size() > idx) return int'(dvBytes[idx]);
    return -1;
  endfunction

  task automatic checkOutput(input string tag, input int observed, input int expected);
    testsRun++;
    if (observed != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
               tag, observed, observed, expected, expected);
    end
  endtask

  task automatic clearCounts();
    deserCount    = 0;
    dvCount       = 0;
    glitchCount   = 0;
    cntEnCycles   = 0;
    badTiming     = 0;
    prevStopCheck = 1'b0;
    shreg         = 8'h00;
    dvBytes.delete();
  endtask

  // Pull the line low for lowCycles clocks, then run the frame until the
  // controller drops cnt_enable (bounded).
  task automatic applyStimulus(input logic [15:0] bits, input int lowCycles);
    frameBits  = bits;
    bus.RX_IN  = 1'b0;
    repeat (lowCycles) @(posedge clk);
    #1;
    bus.RX_IN = 1'b1;
    for (int i = 0; i < 2000 && bus.cnt_enable; i++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("frameEnd", int'(bus.cnt_enable), 0);
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    testsRun     = 0;
    testsFailed  = 0;
    expErrModel  = 0;
    chkExp       = 6;
    frameBits    = 16'hFFFF;
    SRST         = 1'b1;
    bus.RX_IN    = 1'b1;
    bus.PAR_EN   = 1'b0;
    bus.PAR_TYP  = 1'b0;
    bus.Prescale = 6'd8;
    clearCounts();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstCntEn", int'(bus.cnt_enable), 0);
    checkOutput("rstSmpEn", int'(bus.smp_enable), 0);
    checkOutput("rstDeser", int'(bus.deser_en), 0);
    checkOutput("rstValid", int'(bus.data_valid), 0);
    checkOutput("rstErrs", int'({bus.par_err, bus.stp_err, bus.strt_glitch}), 0);
    checkOutput("rstErrCnt", int'(bus.err_cnt), 0);
    SRST = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] frame 0x5A, Prescale 8, no parity");
    clearCounts();
    applyStimulus(makeFrame(8'h5A, 1'b0, 1'b0, 1'b1), 1);
    settle();
    checkOutput("t1Deser", deserCount, 8);
    checkOutput("t1Valid", dvCount, 1);
    checkOutput("t1Byte", firstByte(0), 8'h5A);
    checkOutput("t1ParErr", int'(bus.par_err), 0);
    checkOutput("t1StpErr", int'(bus.stp_err), 0);
    checkOutput("t1Timing", badTiming, 0);

    $display("[TB] frame 0x07, Prescale 16, even parity");
    bus.Prescale = 6'd16;
    chkExp       = 10;
    bus.PAR_EN   = 1'b1;
    bus.PAR_TYP  = 1'b0;
    clearCounts();
    applyStimulus(makeFrame(8'h07, 1'b1, 1'b1, 1'b1), 1);
    settle();
    checkOutput("t2aValid", dvCount, 1);
    checkOutput("t2aByte", firstByte(0), 8'h07);
    checkOutput("t2aParErr", int'(bus.par_err), 0);
    checkOutput("t2aTiming", badTiming, 0);
    clearCounts();
    applyStimulus(makeFrame(8'h07, 1'b1, 1'b0, 1'b1), 1);
    expErrModel++;
    settle();
    checkOutput("t2bValid", dvCount, 0);
    checkOutput("t2bDeser", deserCount, 8);
    checkOutput("t2bParErr", int'(bus.par_err), 1);
    checkOutput("t2bErrCnt", int'(bus.err_cnt), expErr());
    repeat (20) @(negedge clk);
    checkOutput("t2bParHeld", int'(bus.par_err), 1);

    $display("[TB] false start, Prescale 8");
    bus.Prescale = 6'd8;
    chkExp       = 6;
    bus.PAR_EN   = 1'b0;
    clearCounts();
    applyStimulus(makeFrame(8'hFF, 1'b0, 1'b0, 1'b1) | 16'h0001, 2);
    expErrModel++;
    settle();
    checkOutput("t3Glitch", glitchCount, 1);
    checkOutput("t3Deser", deserCount, 0);
    checkOutput("t3Valid", dvCount, 0);
    checkOutput("t3CntEnCycles", cntEnCycles, 7);
    checkOutput("t3ParCleared", int'(bus.par_err), 0);
    checkOutput("t3ErrCnt", int'(bus.err_cnt), expErr());

    $display("[TB] stop error then recovery");
    clearCounts();
    applyStimulus(makeFrame(8'hC3, 1'b0, 1'b0, 1'b0), 1);
    expErrModel++;
    settle();
    checkOutput("t4aStpErr", int'(bus.stp_err), 1);
    checkOutput("t4aValid", dvCount, 0);
    checkOutput("t4aDeser", deserCount, 8);
    checkOutput("t4aErrCnt", int'(bus.err_cnt), expErr());
    clearCounts();
    applyStimulus(makeFrame(8'h3C, 1'b0, 1'b0, 1'b1), 1);
    settle();
    checkOutput("t4bStpErr", int'(bus.stp_err), 0);
    checkOutput("t4bValid", dvCount, 1);
    checkOutput("t4bByte", firstByte(0), 8'h3C);

    $display("[TB] back-to-back frames, Prescale 16");
    bus.Prescale = 6'd16;
    chkExp       = 10;
    clearCounts();
    applyStimulus(makeFrame(8'hA5, 1'b0, 1'b0, 1'b1), 1);
    applyStimulus(makeFrame(8'h81, 1'b0, 1'b0, 1'b1), 1);
    settle();
    checkOutput("t5Valid", dvCount, 2);
    checkOutput("t5Deser", deserCount, 16);
    checkOutput("t5Byte0", firstByte(0), 8'hA5);
    checkOutput("t5Byte1", firstByte(1), 8'h81);
    checkOutput("t5Errs", int'({bus.par_err, bus.stp_err}), 0);
    checkOutput("t5Timing", badTiming, 0);

    $display("[TB] reset during data bit 4");
    bus.Prescale = 6'd8;
    chkExp       = 6;
    clearCounts();
    frameBits = makeFrame(8'hFF, 1'b0, 1'b0, 1'b1);
    bus.RX_IN = 1'b0;
    @(posedge clk);
    #1;
    bus.RX_IN = 1'b1;
    for (int i = 0; i < 500 && !(bus.bit_cnt == 4'd4 && bus.edge_cnt == 5'd2); i++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("t6ReachBit4", int'(bus.bit_cnt), 4);
    SRST = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("t6CntEn", int'(bus.cnt_enable), 0);
    checkOutput("t6SmpEn", int'(bus.smp_enable), 0);
    checkOutput("t6Pulses", int'({bus.deser_en, bus.data_valid, bus.strt_glitch}), 0);
    checkOutput("t6Errs", int'({bus.par_err, bus.stp_err}), 0);
    checkOutput("t6ErrCnt", int'(bus.err_cnt), 0);
    SRST        = 1'b0;
    expErrModel = 0;
    repeat (2) @(posedge clk);
    #1;
    clearCounts();
    applyStimulus(makeFrame(8'h96, 1'b0, 1'b0, 1'b1), 1);
    settle();
    checkOutput("t6Valid", dvCount, 1);
    checkOutput("t6Byte", firstByte(0), 8'h96);
    checkOutput("t6PostErrs", int'({bus.par_err, bus.stp_err}), 0);
    checkOutput("t6PostErrCnt", int'(bus.err_cnt), expErr());

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
